// File: rtl/dft_line_buf.sv
// Ping-pong line buffer behind dft_postproc: fills one bank while the other is held for random-access readout.
// Optional per-line peak tracking is built when DFT_LINE_BUF_PEAK_EN is defined.
module dft_line_buf #(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              line_ready,
  input  logic              line_ack,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overflow,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_idx
);

  localparam int unsigned MEM_D = 2 * DEPTH;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_D];

  logic              wr_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic              line_done_c;
  logic              bank_free_c;
  logic              swap_c;

  logic              rd_req_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] rd_addr_q;

  // A line completes on the write of its last sample; it can only be handed over if the held bank is free.
  assign line_done_c = valid_in && (wr_ptr == LAST_IDX);
  assign bank_free_c = !line_ready || line_ack;
  assign swap_c      = line_done_c && bank_free_c;

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem[{wr_bank, wr_ptr}] <= data_in;
    end
  end

  // Write pointer, bank swap and line handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      line_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (valid_in) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (swap_c) begin
        line_ready <= 1'b1;
        wr_bank    <= ~wr_bank;
      end else begin
        if (line_done_c) begin
          overflow <= 1'b1;
        end
        if (line_ack) begin
          line_ready <= 1'b0;
        end
      end
    end
  end

  // Two-stage read: the held bank is captured with the request, so a read alongside an ack sees the old line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_req_q <= rd_en;
      if (rd_en) begin
        rd_bank_q <= ~wr_bank;
        rd_addr_q <= rd_addr;
      end
      rd_valid <= rd_req_q;
      if (rd_req_q) begin
        rd_data <= mem[{rd_bank_q, rd_addr_q}];
      end
    end
  end

`ifdef DFT_LINE_BUF_PEAK_EN
  logic [DATA_W-1:0] run_max;
  logic [ADDR_W-1:0] run_idx;
  logic              take_c;
  logic [DATA_W-1:0] cand_max_c;
  logic [ADDR_W-1:0] cand_idx_c;

  // Index 0 reloads the running max; afterwards only a strictly larger sample wins, so ties keep the first index.
  assign take_c     = (wr_ptr == '0) || (data_in > run_max);
  assign cand_max_c = take_c ? data_in : run_max;
  assign cand_idx_c = take_c ? wr_ptr : run_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max  <= '0;
      run_idx  <= '0;
      peak_val <= '0;
      peak_idx <= '0;
    end else begin
      if (valid_in) begin
        run_max <= cand_max_c;
        run_idx <= cand_idx_c;
      end
      if (swap_c) begin
        peak_val <= cand_max_c;
        peak_idx <= cand_idx_c;
      end
    end
  end
`else
  assign peak_val = '0;
  assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_dft_line_buf.sv
// Directed bench for dft_line_buf: fill/readback, gapped input, ping-pong, overflow, ack collision, peak tie and reset.
module tb_dft_line_buf;

  localparam int unsigned DATA_W = 15;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;
`ifdef DFT_LINE_BUF_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic              tb_clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              line_ready;
  logic              line_ack = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overflow;
  logic [DATA_W-1:0] peak_val;
  logic [ADDR_W-1:0] peak_idx;

  int n_assert = 0;
  int n_fail   = 0;

  dft_line_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .line_ready(line_ready),
    .line_ack  (line_ack),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .overflow  (overflow),
    .peak_val  (peak_val),
    .peak_idx  (peak_idx)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [31:0] v);
    return PEAK_EN ? v : 32'd0;
  endfunction

  // Line contents: 0 index, 1 constant, 2 index^k, 3 index with 0x7FFF at 10 and 200, 4 k-index.
  function automatic logic [DATA_W-1:0] line_val(input int kind, input logic [DATA_W-1:0] k, input int i);
    case (kind)
      0:       return DATA_W'(i);
      1:       return k;
      2:       return DATA_W'(i) ^ k;
      3:       return (i == 10 || i == 200) ? 15'h7FFF : DATA_W'(i);
      default: return k - DATA_W'(i);
    endcase
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send_range(input int kind, input logic [DATA_W-1:0] k, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      data_in  = line_val(kind, k, i);
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic ack();
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask

  task automatic read_one(input string tag, input int addr, input logic [DATA_W-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(addr);
    tick();
    rd_en = 1'b0;
    tick();
    check(tag, {rd_valid, rd_data}, {1'b1, exp});
  endtask

  // Back-to-back reads of the whole held line; response for request i appears after the second edge.
  task automatic read_line(input string tag, input int kind, input logic [DATA_W-1:0] k);
    for (int i = 0; i <= int'(DEPTH); i++) begin
      rd_en = (i < int'(DEPTH));
      if (i < int'(DEPTH)) rd_addr = ADDR_W'(i);
      tick();
      if (i >= 1) check(tag, {rd_valid, rd_data}, {1'b1, line_val(kind, k, i - 1)});
    end
    rd_en = 1'b0;
    tick();
    check({tag, "_vld_end"}, rd_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, line_ready, 0);
    check({tag, "_rdvld"}, rd_valid, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_rddata"}, rd_data, 0);
    check({tag, "_pkval"}, peak_val, 0);
    check({tag, "_pkidx"}, peak_idx, 0);
  endtask

  initial begin
    int sent;
    int early;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Fill with value = index
    send_range(0, '0, 0, 255);
    check("fill_ready_early", line_ready, 0);
    send_range(0, '0, 255, 256);
    check("fill_ready", line_ready, 1);
    check("fill_pkval", peak_val, pk(32'h0FF));
    check("fill_pkidx", peak_idx, pk(32'd255));
    read_line("fill_rd", 0, '0);
    ack();
    check("fill_ack", line_ready, 0);

    // Gapped bursts of 3 with 109 idle cycles
    sent  = 0;
    early = 0;
    while (sent < int'(DEPTH)) begin
      for (int b = 0; b < 3 && sent < int'(DEPTH); b++) begin
        data_in  = line_val(2, 15'h02A5, sent);
        valid_in = 1'b1;
        tick();
        if (sent < int'(DEPTH) - 1 && line_ready) early++;
        sent++;
      end
      valid_in = 1'b0;
      if (sent < int'(DEPTH)) begin
        for (int g = 0; g < 109; g++) begin
          tick();
          if (line_ready) early++;
        end
      end
    end
    check("gap_early_ready", early, 0);
    check("gap_ready", line_ready, 1);
    check("gap_pkval", peak_val, pk(32'h2FF));
    check("gap_pkidx", peak_idx, pk(32'd90));
    read_line("gap_rd", 2, 15'h02A5);
    ack();

    // Ping-pong: A held while B fills, ack mid-B
    send_range(1, 15'h1111, 0, 256);
    check("pp_a_ready", line_ready, 1);
    check("pp_a_pkval", peak_val, pk(32'h1111));
    check("pp_a_pkidx", peak_idx, pk(32'd0));
    send_range(1, 15'h2222, 0, 100);
    read_one("pp_rd_a5", 5, 15'h1111);
    read_one("pp_rd_a200", 200, 15'h1111);
    ack();
    check("pp_ack", line_ready, 0);
    send_range(1, 15'h2222, 100, 256);
    check("pp_b_ready", line_ready, 1);
    check("pp_ovf", overflow, 0);
    read_one("pp_rd_b0", 0, 15'h2222);
    read_one("pp_rd_b255", 255, 15'h2222);
    check("pp_b_pkval", peak_val, pk(32'h2222));
    ack();

    // Overflow: B dropped while A held, C shown after ack
    send_range(1, 15'h0333, 0, 256);
    send_range(1, 15'h0AAA, 0, 255);
    check("ovf_before_last", overflow, 0);
    send_range(1, 15'h0AAA, 255, 256);
    check("ovf_set", overflow, 1);
    check("ovf_ready", line_ready, 1);
    read_one("ovf_rd_a", 7, 15'h0333);
    check("ovf_pkval", peak_val, pk(32'h0333));
    check("ovf_pkidx", peak_idx, pk(32'd0));
    ack();
    send_range(1, 15'h0555, 0, 256);
    check("ovf_c_ready", line_ready, 1);
    read_one("ovf_rd_c", 100, 15'h0555);
    check("ovf_c_pkval", peak_val, pk(32'h0555));
    check("ovf_sticky", overflow, 1);

    // Reset clears everything, including sticky overflow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst1");

    // Ack in the same cycle as B's last sample
    send_range(1, 15'h0ABC, 0, 256);
    send_range(1, 15'h0DEF, 0, 255);
    read_one("col_rd_a", 3, 15'h0ABC);
    line_ack = 1'b1;
    send_range(1, 15'h0DEF, 255, 256);
    line_ack = 1'b0;
    check("col_ready", line_ready, 1);
    check("col_ovf", overflow, 0);
    read_one("col_rd_b", 3, 15'h0DEF);
    check("col_pkval", peak_val, pk(32'h0DEF));
    ack();

    // Peak tie: first index wins
    send_range(3, '0, 0, 256);
    check("tie_ready", line_ready, 1);
    check("tie_pkval", peak_val, pk(32'h7FFF));
    check("tie_pkidx", peak_idx, pk(32'd10));
    read_one("tie_rd200", 200, 15'h7FFF);

    // Reset at index 100 of the next line, then a clean full line
    send_range(4, 15'h7000, 0, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst2");
    send_range(4, 15'h7000, 0, 255);
    check("post_rst_early", line_ready, 0);
    send_range(4, 15'h7000, 255, 256);
    check("post_rst_ready", line_ready, 1);
    read_one("post_rst_rd0", 0, 15'h7000);
    read_one("post_rst_rd255", 255, 15'h6F01);
    check("post_rst_pkval", peak_val, pk(32'h7000));
    check("post_rst_pkidx", peak_idx, pk(32'd0));
    check("post_rst_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dft_line_buf.md
# dft_line_buf

Ping-pong line buffer that sits directly downstream of `dft_postproc`. It collects one line of `DEPTH` magnitude results from `dft_postproc`'s `data_out`/`valid_out`, then hands the completed line to a random-access reader (SPI/host side) while the next line fills. It also tracks the per-line peak magnitude and its index. It decouples the bursty DFT result stream from a slow readout.

## Interface
- `DATA_W`, 15, magnitude width; matches `dft_postproc` `DATA_W-1`.
- `DEPTH`, 256, results per line; power of two, ≥ 4.
- `ADDR_W`, 8, index width; equals log2(`DEPTH`).

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in `DATA_W`: magnitude sample, connected to `dft_postproc.data_out`.
- `valid_in` in 1: sample valid, connected to `dft_postproc.valid_out`; at most one sample per clock.
- `line_ready` out 1: a completed line is held for reading.
- `line_ack` in 1: single-cycle pulse; releases the held line.
- `rd_en` in 1: read strobe.
- `rd_addr` in `ADDR_W`: index within the held line.
- `rd_data` out `DATA_W`: read data.
- `rd_valid` out 1: `rd_data` is valid.
- `overflow` out 1: sticky; a completed line was dropped.
- `peak_val` out `DATA_W`: maximum sample of the held line.
- `peak_idx` out `ADDR_W`: index of that maximum.

## Operation
- Storage: two banks of `DEPTH` x `DATA_W` (inferred RAM). `wr_bank` points at the filling bank; the other bank is the held bank when `line_ready`=1.
- Write pointer `wr_ptr`: on `valid_in`=1, write `data_in` to `wr_bank[wr_ptr]`, then `wr_ptr` increments. When it wraps from `DEPTH-1` to 0, the line is complete.
- Line complete, other bank free (`line_ready`=0, or `line_ack` in the same cycle): set `line_ready`, toggle `wr_bank`, latch peak registers.
- Line complete, other bank still held (`line_ready`=1, no `line_ack`):
  - Set `overflow`.
  - `wr_bank` does not toggle; the next line overwrites the same bank from index 0.
  - Held line, `peak_val` and `peak_idx` are unchanged.
- `line_ack` with `line_ready`=1: `line_ready` clears next cycle.
- `line_ack` with `line_ready`=0: ignored.
- Read: `rd_en`=1 reads the held bank at `rd_addr`.
  - A read while `line_ready`=0 returns undefined data; `rd_valid` still pulses.
  - A read issued in the same cycle as a `line_ack` uses the bank that was held before the ack.
- Peak tracking, running over the filling line:
  - At index 0, the running max and its index load unconditionally.
  - Afterwards they update only on strictly greater values, so on a tie the first index wins.
  - The completing sample is included before latching.
- `overflow` clears only on `rst`.
- Reset:
  - `line_ready`=0, `rd_valid`=0, `overflow`=0, `rd_data`=0, `peak_val`=0, `peak_idx`=0, `wr_ptr`=0, `wr_bank`=0.
  - RAM contents are not cleared.
  - Reset mid-line discards the partial line and any held line.

## Timing
- Write: a sample presented at edge N is stored at edge N.
- `line_ready` rises, and `peak_*` update, at the edge that stores sample `DEPTH-1`.
- Read latency is 1 clock. `rd_en` at edge N gives `rd_data`/`rd_valid` valid after edge N+1. `rd_valid` is a one-cycle pulse per `rd_en`, and back-to-back reads sustain one per clock.
- `line_ack` at edge N: `line_ready`=0 after edge N. The bank is free for a completion at edge N.
- `overflow` rises at the edge that stores the dropped line's last sample.
- There are no combinational paths from inputs to outputs.

## Configuration
- `DFT_LINE_BUF_PEAK_EN` defined: peak tracking logic is present as described.
- `DFT_LINE_BUF_PEAK_EN` undefined:
  - No comparator or running-max registers are built.
  - `peak_val` and `peak_idx` are tied to 0.
  - All other behaviour is identical.

## Test plan
- Fill: write 256 samples with value = index (0x000..0x0FF).
  - `line_ready` rises on the last write.
  - Reading addresses 0..255 returns 0x000..0x0FF at 1-cycle latency.
  - `peak_val`=0x0FF, `peak_idx`=255.
- Gapped input: send 3-sample bursts separated by 109 idle cycles, as `dft_postproc` produces, until 256 samples have arrived.
  - All 256 samples are stored in order.
  - `line_ready` asserts only after sample 255.
- Ping-pong: fill line A (all 0x1111), ack, fill line B (all 0x2222).
  - While B fills, reads return 0x1111 until the ack.
  - After B completes, reads return 0x2222.
  - `overflow`=0.
- Overflow: fill A, do not ack, fill B (0x0AAA), then fill C (0x0555).
  - `overflow`=1 after B completes.
  - The held line still reads A, and peaks are unchanged.
  - After the ack, the next completion shows line C, not B.
- Ack collision: `line_ack` in the same cycle as line B's last sample.
  - `line_ready` stays 1 and switches to B.
  - `overflow`=0.
- Peak tie and reset: line with 0x7FFF at indices 10 and 200.
  - `peak_idx`=10.
  - Assert `rst` at index 100 of the next line: all outputs return to 0, and the next full line completes normally.
  - With the macro undefined, `peak_val` and `peak_idx` read 0 throughout.
